// File: rtl/bcd_pkg.sv
// Shared types and default sizing for the BCD-to-binary converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DIGITS_DEF = 3;
   localparam int BIN_W_DEF  = 10;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD nibble correction for the reverse double-dabble step.
module bcd_digit_adj (
   input  logic [3:0] digit,
   output logic [3:0] adj
);

   assign adj = (digit >= 4'd8) ? (digit - 4'd3) : digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double dabble, one bit per cycle).
// Optional digit range check enabled by defining BCD_TO_BIN_ERR_EN.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | one shift-and-correct step per cycle, 4*DIGITS cycles
// DONE  | result presented with out_valid until out_ready
module bcd_to_bin
   import bcd_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF,
   parameter int BIN_W  = BIN_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   bcd_code,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [BIN_W-1:0]      bin_code,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  bcd_err
);

   // The binary field is kept at least 4*DIGITS wide so that none of the
   // fixed 4*DIGITS shifts pushes result bits out of the register.
   localparam int BF_W  = (BIN_W > 4*DIGITS) ? BIN_W : 4*DIGITS;
   localparam int WR_W  = 4*DIGITS + BF_W;
   localparam int CNT_W = $clog2(4*DIGITS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(4*DIGITS - 1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [WR_W-1:0]    wr;
   logic [WR_W-1:0]    wr_sh;
   logic [WR_W-1:0]    wr_step;
   logic [BIN_W-1:0]   bin_next;
   logic               accept;

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)       state_nxt = SHIFT;
         SHIFT:   if (cnt == '0)    state_nxt = DONE;
         DONE:    if (out_ready)    state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   assign wr_sh = wr >> 1;
   assign wr_step[BF_W-1:0] = wr_sh[BF_W-1:0];

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit (wr_sh[BF_W + 4*g +: 4]),
         .adj   (wr_step[BF_W + 4*g +: 4])
      );
   end

   // After the final step the value sits at the top of the binary field.
   assign bin_next = BIN_W'(wr_step[BF_W-1:0] >> (BF_W - 4*DIGITS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         wr       <= '0;
         bin_code <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  wr  <= {bcd_code, {BF_W{1'b0}}};
                  cnt <= CNT_LOAD;
               end
            end
            SHIFT: begin
               wr <= wr_step;
               if (cnt == '0) bin_code <= bin_next;
               else           cnt      <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef BCD_TO_BIN_ERR_EN
   logic err_q;

   function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         err_q <= 1'b0;
      else if (accept) err_q <= has_bad_digit(bcd_code);
   end

   assign bcd_err = err_q;
`else
   assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: directed corner cases plus random operands vs a decimal model.
module tb_bcd_to_bin;

   localparam int D = 3;
   localparam int W = 10;

   logic           clk;
   logic           rst;
   logic [4*D-1:0] bcd_code;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   bin_code;
   logic           out_valid;
   logic           out_ready;
   logic           bcd_err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [W-1:0] bin;
      logic         err;
      logic         chk_bin;
   } exp_t;

   exp_t sb[$];

   bcd_to_bin #(.DIGITS(D), .BIN_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bcd_code  (bcd_code),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_code  (bin_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd_err   (bcd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout/unexpected event expected none", name);
   endtask

   function automatic bit ref_bad(input logic [4*D-1:0] v);
      logic [4*D-1:0] t;
      t = v;
      for (int i = 0; i < D; i++) begin
         if (t[3:0] > 4'd9) return 1'b1;
         t = t >> 4;
      end
      return 1'b0;
   endfunction

   function automatic logic [W-1:0] ref_bin(input logic [4*D-1:0] v);
      int s;
      int p;
      logic [4*D-1:0] t;
      s = 0;
      p = 1;
      t = v;
      for (int i = 0; i < D; i++) begin
         s = s + int'(t[3:0]) * p;
         p = p * 10;
         t = t >> 4;
      end
      return W'(s);
   endfunction

   function automatic logic ref_err(input logic [4*D-1:0] v);
`ifdef BCD_TO_BIN_ERR_EN
      return ref_bad(v);
`else
      return 1'b0;
`endif
   endfunction

   // Monitor: every completed output handshake consumes one scoreboard entry.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid) begin
         chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
         if (out_ready) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_out_valid");
            end else begin
               e = sb.pop_front();
               if (e.chk_bin) chk("bin_code", 32'(bin_code), 32'(e.bin));
               chk("bcd_err", 32'(bcd_err), 32'(e.err));
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic send(input logic [4*D-1:0] v, input bit push);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         fail_now("send_wait_in_ready");
      end else begin
         if (push) sb.push_back('{ref_bin(v), ref_err(v), !ref_bad(v)});
         in_valid = 1'b1;
         bcd_code = v;
         @(posedge clk); #1;
         in_valid = 1'b0;
         bcd_code = 12'($urandom);
      end
   endtask

   task automatic drain(input bit rnd);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      if (sb.size() != 0) begin
         fail_now("drain_timeout");
         sb.delete();
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int lat;
      int n;
      logic [4*D-1:0] v;

      rst       = 1'b1;
      in_valid  = 1'b0;
      bcd_code  = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_bin_code",  32'(bin_code),  32'd0);
      chk("rst_bcd_err",   32'(bcd_err),   32'd0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // 0x999 with out_ready already high: 13-cycle latency, one-cycle out_valid
      sb.push_back('{10'h3E7, 1'b0, 1'b1});
      in_valid = 1'b1;
      bcd_code = 12'h999;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (lat < 50) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         lat++;
      end
      chk("latency_999", 32'(lat), 32'd13);
      @(negedge clk);
      chk("one_cycle_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      drain(1'b0);

      send(12'h000, 1'b1);
      drain(1'b0);
      send(12'h001, 1'b1);
      drain(1'b0);

      // Backpressure: result held 5 cycles
      out_ready = 1'b0;
      send(12'h255, 1'b1);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) fail_now("wait_out_valid_255");
      for (int k = 0; k < 5; k++) begin
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_bin_code",  32'(bin_code),  32'h0FF);
         chk("hold_in_ready",  32'(in_ready),  32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain(1'b0);

      // Reset during SHIFT cycle 6 abandons the conversion
      send(12'h777, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_bin_code",  32'(bin_code),  32'd0);
      chk("midrst_in_ready",  32'(in_ready),  32'd0);
      chk("midrst_bcd_err",   32'(bcd_err),   32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      send(12'h512, 1'b1);
      drain(1'b0);

      // in_valid held with another value during SHIFT is ignored
      sb.push_back('{ref_bin(12'h345), 1'b0, 1'b1});
      in_valid = 1'b1;
      bcd_code = 12'h345;
      @(posedge clk); #1;
      bcd_code = 12'h678;
      repeat (6) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain(1'b0);

      // Invalid digit
      send(12'h1A3, 1'b1);
      drain(1'b0);

      for (int it = 0; it < 30; it++) begin
         v = '0;
         for (int i = 0; i < D; i++) begin
            v = v << 4;
            if ($urandom_range(0, 7) == 0) v[3:0] = 4'($urandom_range(10, 15));
            else                           v[3:0] = 4'($urandom_range(0, 9));
         end
         send(v, 1'b1);
         drain(1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of packed BCD input digits.
REQ-002 SHALL have parameter BIN_W, default 10: binary result width; must be >= ceil(log2(10^DIGITS)).
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bcd_code  input  4*DIGITS  packed BCD, most significant digit in the top nibble.
REQ-006 SHALL have port in_valid  input  1  bcd_code is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept a new operand.
REQ-008 SHALL have port bin_code  output  BIN_W  converted binary value.
REQ-009 SHALL have port out_valid  output  1  bin_code and bcd_err are valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port bcd_err  output  1  the accepted operand contained a digit greater than 9.

Function
REQ-012 SHALL use the state machine IDLE -> SHIFT -> DONE -> IDLE.
REQ-013 SHALL drive in_ready high only in IDLE; the operand is accepted on a cycle where in_valid and in_ready are both high.
REQ-014 On accept, SHALL capture bcd_code into a 4*DIGITS + BIN_W working register, with the binary field zeroed, and enter SHIFT.
REQ-015 In SHIFT, SHALL perform one reverse double-dabble step per cycle: shift the whole register right by 1, then subtract 3 from every BCD nibble that is >= 8.
REQ-016 SHALL run exactly 4*DIGITS SHIFT cycles, counted by an iteration counter, and then enter DONE.
REQ-017 In DONE, SHALL hold out_valid high with bin_code and bcd_err stable until out_ready is high; it then returns to IDLE.
REQ-018 Latency SHALL be 4*DIGITS+1 cycles from the accept edge to out_valid rising, which is 13 cycles for DIGITS=3.
REQ-019 While out_valid is low, SHALL keep bin_code at its last delivered value.
REQ-020 in_valid while not in IDLE SHALL be ignored, with no queuing.
REQ-021 If out_ready is already high when DONE is entered, SHALL leave DONE on the next edge, so out_valid is high for one cycle.
REQ-022 SHALL produce the arithmetic result bin_code = sum of digit_i * 10^i, truncated to BIN_W bits.

Reset
REQ-023 rst high SHALL asynchronously force IDLE, with the counter at 0, the working register at 0, bin_code=0, out_valid=0 and bcd_err=0.
REQ-024 While rst is high, in_ready SHALL be 0; after release, in_ready SHALL be 1 in IDLE.
REQ-025 A reset asserted during SHIFT or DONE SHALL abandon the conversion with no out_valid pulse.

Configuration
REQ-026 With BCD_TO_BIN_ERR_EN defined, on accept the block SHALL set bcd_err if any input nibble is greater than 9; the conversion still runs and its result is don't-care.
REQ-027 Without BCD_TO_BIN_ERR_EN defined, bcd_err SHALL be tied to 0 and no digit check logic SHALL exist.

Structure
REQ-028 Package bcd_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default DIGITS and BIN_W constants.
REQ-029 Sub-module bcd_digit_adj SHALL implement the single-nibble "if >= 8 subtract 3" correction, instantiated DIGITS times.

Verification
REQ-030 Input 0x999 accepted with out_ready=1 -> after 13 cycles, out_valid=1 and bin_code=0x3E7 for one cycle.
REQ-031 Inputs 0x000, 0x255 and 0x001 -> bin_code 0x000, 0x0FF and 0x001 respectively, with bcd_err=0.
REQ-032 Input 0x1A3 with BCD_TO_BIN_ERR_EN defined -> bcd_err=1 with out_valid; without the macro -> bcd_err=0.
REQ-033 out_ready held low for 5 cycles after DONE -> out_valid and bin_code stay stable, and in_ready stays 0 until the handshake completes.
REQ-034 rst pulsed at SHIFT cycle 6 -> outputs immediately at reset values, no out_valid; the next operand 0x512 yields 0x200.
REQ-035 in_valid held high with a new value during SHIFT -> it is ignored, and the result matches the originally accepted operand.
